// File: rtl/name_issue_queue_if.sv
// name_issue_queue_if: producer/consumer handshake bundle for name_issue_queue (slave = queue, master = producer/consumer side)
interface name_issue_queue_if #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int LEN_W           = 4,
  parameter int CNT_W           = 4
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] in_name;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [MAX_NAME_LENGTH*WORD_SIZE-1:0] out_name;
  logic [LEN_W-1:0]                     out_len;
  logic [CNT_W-1:0]                     occupancy;
  logic [15:0]                          issued_count;
  modport master (output in_valid, in_name, out_ready,
                  input  in_ready, out_valid, out_name, out_len, occupancy, issued_count);
  modport slave  (input  in_valid, in_name, out_ready,
                  output in_ready, out_valid, out_name, out_len, occupancy, issued_count);
endinterface

// File: rtl/name_issue_queue.sv
// name_issue_queue: in-order FIFO of NDN names with enqueue-time length calc, registered FWFT head; clk, rst_n (async low), q (slave: in_valid/in_ready/in_name, out_valid/out_ready/out_name/out_len, occupancy, issued_count); NAME_ISSUE_STATS_EN enables the saturating issued_count
module name_issue_queue #(
  parameter int WORD_SIZE       = 32,
  parameter int MAX_NAME_LENGTH = 8,
  parameter int DEPTH           = 8,
  parameter int LEN_W           = 4,
  parameter int CNT_W           = 4
) (
  input logic              clk,
  input logic              rst_n,
  name_issue_queue_if.slave q
);
  localparam int NW    = MAX_NAME_LENGTH * WORD_SIZE;
  localparam int PTR_W = $clog2(DEPTH);
  logic [NW-1:0]    mem_name [DEPTH];
  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] occ, occ_nxt;
  logic             push, pop, bypass, head_valid;
  logic [NW-1:0]    head_name;
  logic [LEN_W-1:0] head_len, len;
  assign q.in_ready  = occ != CNT_W'(DEPTH);
  assign q.out_valid = head_valid;
  assign q.out_name  = head_name;
  assign q.out_len   = head_len;
  assign q.occupancy = occ;
  assign push = q.in_valid && q.in_ready;
  assign pop  = head_valid && q.out_ready;
  always_comb begin
    len = LEN_W'(MAX_NAME_LENGTH);
    for (int i = MAX_NAME_LENGTH - 1; i >= 0; i--)
      if (q.in_name[NW-1-i*WORD_SIZE -: WORD_SIZE] == '0) len = LEN_W'(i);
  end
  assign rd_nxt  = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
  assign occ_nxt = (push && !pop) ? occ + CNT_W'(1) : (!push && pop) ? occ - CNT_W'(1) : occ;
  // the incoming name lands in an otherwise-empty queue: its storage slot is not written yet, so forward it
  assign bypass  = push && occ_nxt == CNT_W'(1);
  always_ff @(posedge clk)
    if (push) begin
      mem_name[wr_ptr] <= q.in_name;
      mem_len[wr_ptr]  <= len;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      head_valid <= 1'b0;
      head_name  <= '0;
      head_len   <= '0;
    end else begin
      wr_ptr     <= push ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_ptr     <= rd_nxt;
      occ        <= occ_nxt;
      head_valid <= occ_nxt != '0;
      // when the queue drains, the head registers keep the last issued name
      if (occ_nxt != '0) begin
        head_name <= bypass ? q.in_name : mem_name[rd_nxt];
        head_len  <= bypass ? len : mem_len[rd_nxt];
      end
    end
`ifdef NAME_ISSUE_STATS_EN
  logic [15:0] issued;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) issued <= '0;
    else if (pop && issued != 16'hFFFF) issued <= issued + 16'd1;
  assign q.issued_count = issued;
`else
  assign q.issued_count = 16'h0000;
`endif
endmodule

// File: tb/tb_name_issue_queue.sv
// tb_name_issue_queue: directed self-checking bench for name_issue_queue
module tb_name_issue_queue;
  localparam int W = 32, M = 8, D = 8, LW = 4, CW = 4;
`ifdef NAME_ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int n_cmp = 0, n_err = 0, pops = 0;
  name_issue_queue_if #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .LEN_W(LW), .CNT_W(CW)) q ();
  name_issue_queue #(.WORD_SIZE(W), .MAX_NAME_LENGTH(M), .DEPTH(D), .LEN_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .q(q.master)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [255:0] mk(input logic [31:0] a, b, c, d, e, f, g, h);
    return {a, b, c, d, e, f, g, h};
  endfunction
  function automatic logic [255:0] full_name(input logic [31:0] w0);
    return mk(w0, 32'hA1, 32'hA2, 32'hA3, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
  endfunction
  function automatic logic [15:0] exp_cnt(input int n);
    return STATS ? 16'(n) : 16'h0000;
  endfunction
  logic [255:0] nm;
  int exp_w0;
  initial begin
    rst_n = 1'b0;
    q.in_valid = 1'b0;
    q.out_ready = 1'b0;
    q.in_name = '0;
    repeat (2) step();
    chk("rst out_valid", q.out_valid, 0);
    chk("rst in_ready", q.in_ready, 1);
    chk("rst occupancy", q.occupancy, 0);
    chk("rst out_name", q.out_name, 0);
    chk("rst out_len", q.out_len, 0);
    chk("rst issued", q.issued_count, 0);
    rst_n = 1'b1;
    step();
    // 1: single push, latency 1, len 2
    nm = mk(32'h1, 32'h2, 0, 0, 0, 0, 0, 0);
    q.out_ready = 1'b1;
    q.in_valid = 1'b1;
    q.in_name = nm;
    chk("t1 pre out_valid", q.out_valid, 0);
    step();
    q.in_valid = 1'b0;
    chk("t1 out_valid", q.out_valid, 1);
    chk("t1 out_name", q.out_name, nm);
    chk("t1 out_len", q.out_len, 2);
    chk("t1 occupancy", q.occupancy, 1);
    step();
    pops = 1;
    chk("t1 drained valid", q.out_valid, 0);
    chk("t1 drained occ", q.occupancy, 0);
    chk("t1 issued", q.issued_count, exp_cnt(pops));
    // 2: fill to full, refuse 9th, drain in order
    q.out_ready = 1'b0;
    q.in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      q.in_name = full_name(32'(k));
      step();
    end
    chk("t2 occ full", q.occupancy, 8);
    chk("t2 in_ready full", q.in_ready, 0);
    q.in_name = full_name(32'd9);
    step();
    chk("t2 refused occ", q.occupancy, 8);
    chk("t2 head still 1", q.out_name[255-:32], 1);
    q.in_valid = 1'b0;
    q.out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk("t2 drain valid", q.out_valid, 1);
      chk("t2 drain name", q.out_name, full_name(32'(k)));
      chk("t2 drain len", q.out_len, 8);
      step();
    end
    pops += 8;
    chk("t2 empty occ", q.occupancy, 0);
    chk("t2 empty valid", q.out_valid, 0);
    // 3: steady stream at occupancy 1
    q.out_ready = 1'b0;
    q.in_valid = 1'b1;
    q.in_name = full_name(32'd100);
    step();
    q.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      q.in_name = full_name(32'(101 + c));
      chk("t3 occ", q.occupancy, 1);
      chk("t3 head", q.out_name[255-:32], 32'(100 + c));
      step();
    end
    pops += 20;
    q.in_valid = 1'b0;
    q.out_ready = 1'b0;
    chk("t3 end occ", q.occupancy, 1);
    chk("t3 end head", q.out_name[255-:32], 120);
    chk("t3 issued", q.issued_count, exp_cnt(pops));
    // 4: backpressure toggling
    q.in_valid = 1'b1;
    for (int k = 121; k <= 123; k++) begin
      q.in_name = full_name(32'(k));
      step();
    end
    q.in_valid = 1'b0;
    chk("t4 occ", q.occupancy, 4);
    exp_w0 = 120;
    for (int c = 0; c < 8; c++) begin
      q.out_ready = c[0];
      chk("t4 valid", q.out_valid, 1);
      chk("t4 head", q.out_name, full_name(32'(exp_w0)));
      chk("t4 len", q.out_len, 8);
      step();
      if (c[0]) exp_w0++;
    end
    pops += 4;
    q.out_ready = 1'b0;
    chk("t4 drained valid", q.out_valid, 0);
    chk("t4 hold name", q.out_name[255-:32], 123);
    // 5: length edges
    q.in_valid = 1'b1;
    q.in_name = '0;
    step();
    q.in_name = mk(32'h5, 0, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7, 32'h7);
    step();
    q.in_name = mk(32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA, 32'hB, 0);
    step();
    q.in_name = full_name(32'hFFFF_FFFF);
    step();
    q.in_valid = 1'b0;
    q.out_ready = 1'b1;
    chk("t5 zero valid", q.out_valid, 1);
    chk("t5 zero len", q.out_len, 0);
    chk("t5 zero name", q.out_name, 0);
    step();
    chk("t5 len1", q.out_len, 1);
    step();
    chk("t5 len7", q.out_len, 7);
    step();
    chk("t5 len8", q.out_len, 8);
    step();
    pops += 4;
    chk("t5 empty", q.out_valid, 0);
    chk("t5 issued", q.issued_count, exp_cnt(pops));
    // 6: async reset mid-cycle with 5 queued
    q.out_ready = 1'b0;
    q.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      q.in_name = full_name(32'(200 + k));
      step();
    end
    q.in_valid = 1'b0;
    chk("t6 occ5", q.occupancy, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 async valid", q.out_valid, 0);
    chk("t6 async occ", q.occupancy, 0);
    chk("t6 async issued", q.issued_count, 0);
    chk("t6 async in_ready", q.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    nm = mk(32'hCAFE, 32'hBEEF, 32'h1, 0, 32'h9, 0, 0, 0);
    q.in_valid = 1'b1;
    q.in_name = nm;
    step();
    q.in_valid = 1'b0;
    chk("t6 post valid", q.out_valid, 1);
    chk("t6 post name", q.out_name, nm);
    chk("t6 post len", q.out_len, 3);
    chk("t6 post occ", q.occupancy, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
